// File: rtl/simple_ram_be_clr.sv
// Simple dual-port RAM with per-lane byte enables, optional registered read with
// read-during-write bypass, and a clear sequencer that fills the array with CLR_VAL.
module simple_ram_be_clr #(
    parameter int               width   = 16,
    parameter int               widthad = 4,
    parameter int               lane    = 8,
    parameter int               RD_REG  = 1,
    parameter int               BYPASS  = 1,
    parameter logic [width-1:0] CLR_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_req,
    output logic                    clr_busy,
    input  logic [widthad-1:0]      wraddress,
    input  logic                    wren,
    input  logic [width/lane-1:0]   wrbe,
    input  logic [width-1:0]        data,
    input  logic [widthad-1:0]      rdaddress,
    input  logic                    rden,
    output logic [width-1:0]        q,
    output logic                    q_valid
);

    localparam int NL    = width / lane;
    localparam int DEPTH = 2 ** widthad;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [widthad-1:0]   clr_cnt_q, clr_cnt_d;

    logic                 mem_we;
    logic [widthad-1:0]   mem_waddr;
    logic [width-1:0]     mem_wdata;
    logic [NL-1:0]        mem_wbe;

    logic [width-1:0]     mem [DEPTH];

    // The sequencer owns the single write port while clearing; user writes are dropped.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = wraddress;
        mem_wdata = data;
        mem_wbe   = wrbe;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = CLR_VAL;
                mem_wbe   = '1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {widthad{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                mem_we = wren;
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NL; i++) begin
                if (mem_wbe[i]) begin
                    mem[mem_waddr][i*lane +: lane] <= mem_wdata[i*lane +: lane];
                end
            end
        end
    end

    assign clr_busy = (state_q == ST_CLEAR);

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [width-1:0] q_q, q_d;
            logic             q_valid_q, q_valid_d;
            logic [width-1:0] rd_word;

            // Entering CLEAR (clr_req in IDLE) suppresses the read so q_valid drops on that edge.
            always_comb begin
                rd_word = mem[rdaddress];
                if ((BYPASS != 0) && wren && (wraddress == rdaddress)) begin
                    for (int i = 0; i < NL; i++) begin
                        if (wrbe[i]) begin
                            rd_word[i*lane +: lane] = data[i*lane +: lane];
                        end
                    end
                end
                q_d       = q_q;
                q_valid_d = 1'b0;
                if ((state_q == ST_IDLE) && !clr_req && rden) begin
                    q_d       = rd_word;
                    q_valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_q       <= '0;
                    q_valid_q <= 1'b0;
                end else begin
                    q_q       <= q_d;
                    q_valid_q <= q_valid_d;
                end
            end

            assign q       = q_q;
            assign q_valid = q_valid_q;
        end else begin : g_rd_comb
            assign q       = mem[rdaddress];
            assign q_valid = (state_q == ST_IDLE);
        end
    endgenerate

endmodule

// File: tb/tb_simple_ram_be_clr.sv
// Directed bench for simple_ram_be_clr: three instances (registered+bypass,
// registered without bypass, combinational read) driven by the same stimulus.
module tb_simple_ram_be_clr;

    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic [2:0]  wraddress;
    logic        wren;
    logic [1:0]  wrbe;
    logic [15:0] data;
    logic [2:0]  rdaddress;
    logic        rden;

    logic        busyA, busyB, busyC;
    logic [15:0] qA, qB, qC;
    logic        qvA, qvB, qvC;

    int checks = 0;
    int errors = 0;
    int cnt;

    simple_ram_be_clr #(.width(16), .widthad(3), .lane(8), .RD_REG(1), .BYPASS(1), .CLR_VAL(16'hA5A5)) dutA (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busyA),
        .wraddress(wraddress), .wren(wren), .wrbe(wrbe), .data(data),
        .rdaddress(rdaddress), .rden(rden), .q(qA), .q_valid(qvA));

    simple_ram_be_clr #(.width(16), .widthad(3), .lane(8), .RD_REG(1), .BYPASS(0), .CLR_VAL(16'hA5A5)) dutB (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busyB),
        .wraddress(wraddress), .wren(wren), .wrbe(wrbe), .data(data),
        .rdaddress(rdaddress), .rden(rden), .q(qB), .q_valid(qvB));

    simple_ram_be_clr #(.width(16), .widthad(3), .lane(8), .RD_REG(0), .BYPASS(0), .CLR_VAL(16'hA5A5)) dutC (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busyC),
        .wraddress(wraddress), .wren(wren), .wrbe(wrbe), .data(data),
        .rdaddress(rdaddress), .rden(rden), .q(qC), .q_valid(qvC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [15:0] d,
                                 input logic [1:0] be, input logic re, input logic [2:0] ra);
        wren      = we;
        wraddress = wa;
        data      = d;
        wrbe      = be;
        rden      = re;
        rdaddress = ra;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts edges until clr_busy falls, bounded so a stuck sequencer cannot hang the run.
    task automatic waitClearDone(inout int n);
        while (busyA && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        clr_req = 1'b0;
        applyStimulus(1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0);
        tick();
        tick();

        checkOutput("reset_busy", {31'd0, busyA}, 32'd1);
        checkOutput("reset_q", {16'd0, qA}, 32'h0);
        checkOutput("reset_qv", {31'd0, qvA}, 32'd0);
        checkOutput("reset_qvC", {31'd0, qvC}, 32'd0);

        // 1. Initial clear length and contents
        rst_n = 1'b1;
        cnt = 0;
        waitClearDone(cnt);
        checkOutput("init_clear_len", cnt, 32'd8);
        checkOutput("init_busyC", {31'd0, busyC}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'(a));
            #1;
            checkOutput($sformatf("init_qC_%0d", a), {16'd0, qC}, 32'hA5A5);
            tick();
            checkOutput($sformatf("init_qA_%0d", a), {16'd0, qA}, 32'hA5A5);
            checkOutput($sformatf("init_qvA_%0d", a), {31'd0, qvA}, 32'd1);
        end
        applyStimulus(1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0);
        tick();
        checkOutput("idle_qv_drop", {31'd0, qvA}, 32'd0);
        checkOutput("idle_q_hold", {16'd0, qA}, 32'hA5A5);

        // 2. Lane-masked write
        applyStimulus(1'b1, 3'd3, 16'h1234, 2'b11, 1'b0, 3'd0);
        tick();
        applyStimulus(1'b1, 3'd3, 16'hFF00, 2'b10, 1'b0, 3'd0);
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd3);
        tick();
        checkOutput("lane_merge_A", {16'd0, qA}, 32'hFF34);
        checkOutput("lane_merge_C", {16'd0, qC}, 32'hFF34);

        // 3. Read-during-write to the same address
        applyStimulus(1'b1, 3'd5, 16'hBEEF, 2'b01, 1'b1, 3'd5);
        tick();
        checkOutput("rdw_bypass", {16'd0, qA}, 32'hA5EF);
        checkOutput("rdw_nobypass", {16'd0, qB}, 32'hA5A5);
        applyStimulus(1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd5);
        tick();
        checkOutput("rdw_after_A", {16'd0, qA}, 32'hA5EF);
        checkOutput("rdw_after_B", {16'd0, qB}, 32'hA5EF);
        applyStimulus(1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0);

        // 4. Writes and reads are dropped while clearing
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        checkOutput("clr_busy_start", {31'd0, busyA}, 32'd1);
        checkOutput("clr_qv_start", {31'd0, qvA}, 32'd0);
        cnt = 1;
        tick();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 3'd2, 16'h1111, 2'b11, 1'b1, 3'd2);
            tick();
            cnt++;
            checkOutput($sformatf("clr_qv_%0d", k), {31'd0, qvA}, 32'd0);
            checkOutput($sformatf("clr_qvC_%0d", k), {31'd0, qvC}, 32'd0);
        end
        applyStimulus(1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0);
        waitClearDone(cnt);
        checkOutput("req_clear_len", cnt, 32'd8);
        checkOutput("clr_q_held", {16'd0, qA}, 32'hA5EF);
        applyStimulus(1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd2);
        tick();
        checkOutput("clr_drop_addr2", {16'd0, qA}, 32'hA5A5);
        applyStimulus(1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd3);
        tick();
        checkOutput("clr_addr3", {16'd0, qA}, 32'hA5A5);
        applyStimulus(1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0);

        // 5. Reset aborts a clear; a second request does not extend the new one
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_q", {16'd0, qA}, 32'h0);
        checkOutput("abort_qv", {31'd0, qvA}, 32'd0);
        checkOutput("abort_busy", {31'd0, busyA}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            cnt++;
        end
        clr_req = 1'b1;
        tick();
        cnt++;
        clr_req = 1'b0;
        waitClearDone(cnt);
        checkOutput("restart_clear_len", cnt, 32'd8);
        applyStimulus(1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd5);
        tick();
        checkOutput("restart_addr5", {16'd0, qA}, 32'hA5A5);

        // 6. Combinational read path around a write, and an all-lanes-off write
        applyStimulus(1'b1, 3'd7, 16'h0F0F, 2'b11, 1'b0, 3'd7);
        #1;
        checkOutput("comb_old", {16'd0, qC}, 32'hA5A5);
        checkOutput("comb_qv", {31'd0, qvC}, 32'd1);
        tick();
        checkOutput("comb_new", {16'd0, qC}, 32'h0F0F);
        applyStimulus(1'b1, 3'd7, 16'hFFFF, 2'b00, 1'b0, 3'd7);
        tick();
        checkOutput("be_zero_noop", {16'd0, qC}, 32'h0F0F);
        applyStimulus(1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd7);
        tick();
        checkOutput("be_zero_noop_A", {16'd0, qA}, 32'h0F0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
